capture_buffer_mc: RTL
======================

CAPTURE_BUFFER_MC -- requirements
Module: capture_buffer_mc

Interface
REQ-001 Param buffer_length, 16, samples stored per channel; SHALL be a power of two.
REQ-002 Param index_bits, 4, address width; SHALL equal log2(buffer_length).
REQ-003 Param i_bits, 12, signed I sample width.
REQ-004 Param q_bits, 12, signed Q sample width; i_bits+q_bits <= 32.
REQ-005 Param channels, 2, independent IQ channels; chan_bits, 1, SHALL equal max(1, log2(channels)).
REQ-006 Port clk  in  1  single clock, all logic rising-edge.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports s_axis_tvalid in 1; s_axis_ti in channels*i_bits; s_axis_tq in channels*q_bits: live sample stream, channel k in slice k.
REQ-009 Ports arm in 1, trigger in 1 (capture control pulses); capture_done out 1 (level, high in DONE).
REQ-010 Ports pretrig in index_bits: samples kept before trigger, sampled on arm.
REQ-011 Ports m_axi_raddr in index_bits; m_axi_rchan in chan_bits; m_axi_rvalid in 1; s_axi_rready out 1: read request.
REQ-012 Ports i out i_bits signed; q out q_bits signed; s_axis_rvalid out 1; m_axi_rready in 1: read data.
REQ-013 Ports m_axi_waddr in index_bits; m_axi_wchan in chan_bits; m_axi_wvalid in 1; s_axi_wready out 1; m_axi_wdata in 32: host write, I in [i_bits-1:0], Q in [i_bits+q_bits-1:i_bits].
REQ-014 Ports s_axi_bresp out 1 (0 OKAY, 1 SLVERR); s_axi_bvalid out 1; m_axi_bready in 1: write response.

Function
REQ-015 Capture FSM states IDLE, ARMED, CAPTURE, DONE; SHALL enter IDLE on reset.
REQ-016 IDLE->ARMED on arm; SHALL latch pretrig, reset write pointer to 0.
REQ-017 ARMED: each s_axis_tvalid cycle SHALL write all channels at write pointer, pointer increments mod buffer_length.
REQ-018 ARMED->CAPTURE on trigger only after at least pretrig samples stored; earlier triggers SHALL be ignored.
REQ-019 Trigger and tvalid in same cycle: that sample SHALL be stored and counted as first post-trigger sample.
REQ-020 CAPTURE: store buffer_length-pretrig samples including trigger sample, then -> DONE; start address = trigger pointer minus pretrig mod buffer_length.
REQ-021 Reads SHALL be logical: physical address = (start + m_axi_raddr) mod buffer_length, so raddr 0 is the oldest sample.
REQ-022 DONE->ARMED on arm (re-arm); arm in ARMED/CAPTURE SHALL restart ARMED.
REQ-023 Read handshake: s_axi_rready high when no read data pending; request accepted when m_axi_rvalid && s_axi_rready.
REQ-024 Read data SHALL appear one cycle after accept with s_axis_rvalid=1; held stable until m_axi_rready; s_axi_rready low meanwhile.
REQ-025 Reads in IDLE/DONE SHALL return memory; reads in ARMED/CAPTURE SHALL return 0 data.
REQ-026 Write handshake: s_axi_wready high when no response pending; accept on m_axi_wvalid && s_axi_wready.
REQ-027 Host write SHALL update memory at physical m_axi_waddr only in IDLE/DONE with bresp=0; in ARMED/CAPTURE memory unchanged, bresp=1.
REQ-028 Out-of-range m_axi_rchan/m_axi_wchan (>= channels): read returns 0, write ignored with bresp=1.
REQ-029 s_axi_bvalid SHALL assert the cycle after accept, held until m_axi_bready.
REQ-030 Host write and stream write never collide (REQ-027); simultaneous read and write SHALL both be accepted, read returns pre-write data.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, pointers 0, capture_done 0, s_axis_rvalid 0, s_axi_bvalid 0, s_axi_bresp 0, i 0, q 0, s_axi_rready 1, s_axi_wready 1.
REQ-032 Memory contents SHALL NOT be reset; reset mid-capture SHALL abort with no further writes.
REQ-033 Reset deassertion SHALL be synchronised externally; first edge after release is a normal cycle.

Structure
REQ-034 Shared package capture_pkg SHALL hold the FSM state encoding and bresp codes OKAY/SLVERR.
REQ-035 Per-channel storage SHALL be one sub-module capture_ram (1 write, 1 sync read port), instantiated channels times.

Verification
REQ-036 Host write ch1 addr 3 data 0x00ABC123 in IDLE, read ch1 addr 3 -> i=0x123, q=0xABC (sign-extended), bresp 0.
REQ-037 pretrig=4, arm, stream ramp 0..40, trigger at sample 10 -> DONE after 12 more samples; read addr 0..15 returns 6..21.
REQ-038 Trigger after 2 samples with pretrig=4 -> ignored, state ARMED; later trigger at sample 5 accepted.
REQ-039 Host write during CAPTURE -> bresp 1, memory unchanged; read during ARMED -> i=q=0.
REQ-040 m_axi_rready held low 5 cycles -> i/q/s_axis_rvalid stable, s_axi_rready 0; new request accepted only after completion.
REQ-041 rst_n low mid-CAPTURE -> all outputs at REQ-031 values same cycle; earlier host-written data still readable.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: capture FSM state encoding and write-response codes shared by the capture buffer
package capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam logic OKAY = 1'b0;
  localparam logic SLVERR = 1'b1;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: per-channel IQ sample store with one write port and one registered, enable-held read port
module capture_ram
  import capture_pkg::*;
#(
  parameter int index_bits = 4,
  parameter int width = 24
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [index_bits-1:0] waddr,
  input  logic [width-1:0]      wdata,
  input  logic                  re,
  input  logic [index_bits-1:0] raddr,
  output logic [width-1:0]      rdata
);
  logic [width-1:0] mem [2**index_bits];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/capture_buffer_mc.sv
// capture_buffer_mc: multi-channel pre/post-trigger IQ capture buffer with host read and write ports
module capture_buffer_mc
  import capture_pkg::*;
#(
  parameter int buffer_length = 16,
  parameter int index_bits = 4,
  parameter int i_bits = 12,
  parameter int q_bits = 12,
  parameter int channels = 2,
  parameter int chan_bits = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_axis_tvalid,
  input  logic [channels*i_bits-1:0]   s_axis_ti,
  input  logic [channels*q_bits-1:0]   s_axis_tq,
  input  logic                         arm,
  input  logic                         trigger,
  output logic                         capture_done,
  input  logic [index_bits-1:0]        pretrig,
  input  logic [index_bits-1:0]        m_axi_raddr,
  input  logic [chan_bits-1:0]         m_axi_rchan,
  input  logic                         m_axi_rvalid,
  output logic                         s_axi_rready,
  output logic signed [i_bits-1:0]     i,
  output logic signed [q_bits-1:0]     q,
  output logic                         s_axis_rvalid,
  input  logic                         m_axi_rready,
  input  logic [index_bits-1:0]        m_axi_waddr,
  input  logic [chan_bits-1:0]         m_axi_wchan,
  input  logic                         m_axi_wvalid,
  output logic                         s_axi_wready,
  input  logic [31:0]                  m_axi_wdata,
  output logic                         s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         m_axi_bready
);
  localparam int w = i_bits + q_bits;
  localparam logic [index_bits:0] full = (index_bits + 1)'(buffer_length);
  state_t state, state_nx;
  logic [index_bits-1:0] wptr, start, pre, rd_addr;
  logic [index_bits:0] stored, rem, rem_init;
  logic [chan_bits-1:0] rchan_q;
  logic [w-1:0] rdata [channels];
  logic [w-1:0] sel;
  logic busy, stream_we, trig_ok, last, rd_acc, wr_acc, host_ok, host_we, rzero, rd_live;
  logic unused_wdata;
  assign unused_wdata = ^m_axi_wdata;
  assign busy = state == ARMED || state == CAPTURE;
  assign stream_we = busy && s_axis_tvalid && !arm;
  assign trig_ok = state == ARMED && trigger && !arm && stored >= {1'b0, pre};
  assign rem_init = full - {1'b0, pre} - (index_bits + 1)'(s_axis_tvalid);
  assign last = state == CAPTURE && stream_we && rem == (index_bits + 1)'(1);
  assign capture_done = state == DONE;
  assign s_axi_rready = !s_axis_rvalid;
  assign s_axi_wready = !s_axi_bvalid;
  assign rd_acc = m_axi_rvalid && s_axi_rready;
  assign wr_acc = m_axi_wvalid && s_axi_wready;
  assign host_ok = !busy && int'(m_axi_wchan) < channels;
  assign host_we = wr_acc && host_ok;
  assign rd_addr = start + m_axi_raddr;
  assign rd_live = s_axis_rvalid && !rzero;
  assign i = rd_live ? sel[i_bits-1:0] : '0;
  assign q = rd_live ? sel[w-1:i_bits] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = arm ? ARMED : trig_ok ? (rem_init == '0 ? DONE : CAPTURE) : last ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      start <= '0;
      pre <= '0;
      stored <= '0;
      rem <= '0;
    end else if (arm) begin
      pre <= pretrig;
      wptr <= '0;
      stored <= '0;
    end else begin
      if (stream_we) wptr <= wptr + 1'b1;
      if (state == ARMED && stream_we && stored != full) stored <= stored + 1'b1;
      if (trig_ok) begin
        start <= wptr - pre;
        rem <= rem_init;
      end else if (state == CAPTURE && stream_we) rem <= rem - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_rvalid <= 1'b0;
      rzero <= 1'b0;
      rchan_q <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= OKAY;
    end else begin
      if (rd_acc) begin
        s_axis_rvalid <= 1'b1;
        rzero <= busy || int'(m_axi_rchan) >= channels;
        rchan_q <= m_axi_rchan;
      end else if (m_axi_rready) s_axis_rvalid <= 1'b0;
      if (wr_acc) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= host_ok ? OKAY : SLVERR;
      end else if (m_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end
  always_comb begin
    sel = '0;
    for (int k = 0; k < channels; k++) if (int'(rchan_q) == k) sel = rdata[k];
  end
  for (genvar k = 0; k < channels; k++) begin : g_ch
    capture_ram #(.index_bits(index_bits), .width(w)) u_ram (
      .clk(clk),
      .we(stream_we || (host_we && int'(m_axi_wchan) == k)),
      .waddr(stream_we ? wptr : m_axi_waddr),
      .wdata(stream_we ? {s_axis_tq[k*q_bits +: q_bits], s_axis_ti[k*i_bits +: i_bits]} : m_axi_wdata[w-1:0]),
      .re(rd_acc),
      .raddr(rd_addr),
      .rdata(rdata[k])
    );
  end
endmodule
